// File: rtl/signal_tracker_ctrl_pkg.sv
// Shared types for the signal tracker query arbiter: FSM states, error codes
// and the start/end time pair returned by the tracker.
package signal_tracker_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_CLEAR   = 3'd3,
      S_RESPOND = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_RANGE   = 2'd1,
      ERR_TIMEOUT = 2'd2
   } err_t;

   localparam logic signed [31:0] TIME_NONE = -32'sd1;

   typedef struct packed {
      logic signed [31:0] t_end;
      logic signed [31:0] t_start;
   } time_pair_t;

endpackage

// File: rtl/signal_tracker_query_arbiter_rr_arbiter.sv
// Round-robin picker: searches from last_grant+1 (mod NUM_REQ) for the first
// pending request and reports it as one-hot and as an index.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any
);

   int unsigned cand;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      cand       = 0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = (32'(last_grant) + i) % NUM_REQ;
         if (!any && req[IDX_W'(cand)]) begin
            any                     = 1'b1;
            gnt_idx                 = IDX_W'(cand);
            gnt_onehot[IDX_W'(cand)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/signal_tracker_query_arbiter.sv
// Shares one signal tracker among NUM_REQ requesters: round-robin grant, range
// check, recalculate/clear handshake with timeout, one-cycle response.
module signal_tracker_query_arbiter
   import signal_tracker_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned BUFFER_WIDTH   = 8,
   parameter int unsigned TIMEOUT_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0][31:0]      req_value,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic signed [31:0]            resp_start,
   output logic signed [31:0]            resp_end,
   output logic [1:0]                    resp_err,
   output logic                          busy,
   output logic [31:0]                   trk_counter,
   output logic [31:0]                   trk_value_in,
   output logic                          trk_recalculate,
   input  logic [1:0][31:0]              trk_time_out,
   input  logic                          trk_data_valid
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] last_grant, last_nxt;
   logic [IDX_W-1:0] cur, cur_nxt;
   logic [31:0]      value_nxt;
   logic [TO_W-1:0]  to_cnt, to_nxt;
   time_pair_t       res_q, res_nxt;
   err_t             err_q, err_nxt;
   logic             stale, stale_nxt;

   logic [NUM_REQ-1:0] gnt_onehot;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic [31:0]        value_sel;
   logic               range_fail;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (gnt_any)
   );

   // A query can only look back as far as both the history depth and elapsed time allow
   assign value_sel  = req_value[gnt_idx];
   assign range_fail = (value_sel > 32'(BUFFER_WIDTH)) ||
                       ((trk_counter < 32'(BUFFER_WIDTH)) && (value_sel > trk_counter));

   always_comb begin
      state_nxt = state;
      last_nxt  = last_grant;
      cur_nxt   = cur;
      value_nxt = trk_value_in;
      to_nxt    = to_cnt;
      res_nxt   = res_q;
      err_nxt   = err_q;
      stale_nxt = stale;
      req_ready = '0;
      case (state)
         S_IDLE: begin
            if (trk_data_valid) begin
               state_nxt = S_CLEAR;
               stale_nxt = 1'b1;
            end else begin
               req_ready = gnt_onehot;
               if (gnt_any) begin
                  last_nxt  = gnt_idx;
                  cur_nxt   = gnt_idx;
                  value_nxt = value_sel;
                  stale_nxt = 1'b0;
                  if (range_fail) begin
                     res_nxt   = '{t_end: TIME_NONE, t_start: TIME_NONE};
                     err_nxt   = ERR_RANGE;
                     state_nxt = S_RESPOND;
                  end else begin
                     state_nxt = S_ISSUE;
                  end
               end
            end
         end
         S_ISSUE: begin
            state_nxt = S_WAIT;
            to_nxt    = '0;
         end
         S_WAIT: begin
            if (trk_data_valid) begin
               res_nxt.t_start = trk_time_out[0];
               res_nxt.t_end   = trk_time_out[1];
               err_nxt         = ERR_OK;
               state_nxt       = S_CLEAR;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               res_nxt   = '{t_end: TIME_NONE, t_start: TIME_NONE};
               err_nxt   = ERR_TIMEOUT;
               state_nxt = S_RESPOND;
            end else begin
               to_nxt = to_cnt + TO_W'(1);
            end
         end
         S_CLEAR:   state_nxt = stale ? S_IDLE : S_RESPOND;
         S_RESPOND: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // State and internal latches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         last_grant   <= IDX_W'(NUM_REQ - 1);
         cur          <= '0;
         trk_value_in <= '0;
         to_cnt       <= '0;
         res_q        <= '{t_end: TIME_NONE, t_start: TIME_NONE};
         err_q        <= ERR_OK;
         stale        <= 1'b0;
      end else begin
         state        <= state_nxt;
         last_grant   <= last_nxt;
         cur          <= cur_nxt;
         trk_value_in <= value_nxt;
         to_cnt       <= to_nxt;
         res_q        <= res_nxt;
         err_q        <= err_nxt;
         stale        <= stale_nxt;
      end
   end

   // Registered outputs, decoded from the upcoming state so they align with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trk_counter     <= '0;
         trk_recalculate <= 1'b0;
         busy            <= 1'b0;
         resp_valid      <= '0;
         resp_start      <= TIME_NONE;
         resp_end        <= TIME_NONE;
         resp_err        <= 2'(ERR_OK);
      end else begin
         trk_counter     <= trk_counter + 32'd1;
         trk_recalculate <= (state_nxt == S_ISSUE) || (state_nxt == S_CLEAR);
         busy            <= (state_nxt != S_IDLE);
         resp_valid      <= '0;
         if (state_nxt == S_RESPOND) begin
            resp_valid[cur_nxt] <= 1'b1;
            resp_start          <= res_nxt.t_start;
            resp_end            <= res_nxt.t_end;
            resp_err            <= 2'(err_nxt);
         end
      end
   end

endmodule

// File: tb/tb_signal_tracker_query_arbiter.sv
// Directed bench for signal_tracker_query_arbiter; the tracker side is driven by hand.
module tb_signal_tracker_query_arbiter;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       req_valid;
   logic [3:0][31:0] req_value;
   logic [3:0]       req_ready;
   logic [3:0]       resp_valid;
   logic signed [31:0] resp_start;
   logic signed [31:0] resp_end;
   logic [1:0]       resp_err;
   logic             busy;
   logic [31:0]      trk_counter;
   logic [31:0]      trk_value_in;
   logic             trk_recalculate;
   logic [1:0][31:0] trk_time_out;
   logic             trk_data_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   signal_tracker_query_arbiter #(
      .NUM_REQ(4), .BUFFER_WIDTH(8), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_value(req_value), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_start(resp_start), .resp_end(resp_end),
      .resp_err(resp_err), .busy(busy),
      .trk_counter(trk_counter), .trk_value_in(trk_value_in),
      .trk_recalculate(trk_recalculate),
      .trk_time_out(trk_time_out), .trk_data_valid(trk_data_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_count(input logic [31:0] n);
      int k = 0;
      while (trk_counter != n && k < 200) begin
         step();
         k++;
      end
      chk("wait_count", trk_counter, n);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      req_valid      = '0;
      req_value      = '0;
      trk_time_out   = '0;
      trk_data_valid = 1'b0;
      step();
      step();

      // Reset state
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_start", 32'(resp_start), 32'hFFFF_FFFF);
      chk("rst_end", 32'(resp_end), 32'hFFFF_FFFF);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_counter", trk_counter, 32'd0);
      chk("rst_value_in", trk_value_in, 32'd0);
      chk("rst_recalc", 32'(trk_recalculate), 32'd0);
      rst = 1'b0;

      // Nominal query: req0 value 3 at counter 20, tracker answers {17,18}
      wait_count(32'd20);
      req_valid[0] = 1'b1;
      req_value[0] = 32'd3;
      #1 chk("nom_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;
      chk("nom_issue_recalc", 32'(trk_recalculate), 32'd1);
      chk("nom_issue_busy", 32'(busy), 32'd1);
      chk("nom_value_in", trk_value_in, 32'd3);
      step();
      chk("nom_wait_recalc", 32'(trk_recalculate), 32'd0);
      trk_data_valid  = 1'b1;
      trk_time_out[0] = 32'd17;
      trk_time_out[1] = 32'd18;
      step();
      chk("nom_clear_recalc", 32'(trk_recalculate), 32'd1);
      chk("nom_clear_noresp", 32'(resp_valid), 32'd0);
      trk_data_valid = 1'b0;
      step();
      chk("nom_resp_valid", 32'(resp_valid), 32'h1);
      chk("nom_resp_start", 32'(resp_start), 32'd17);
      chk("nom_resp_end", 32'(resp_end), 32'd18);
      chk("nom_resp_err", 32'(resp_err), 32'd0);
      step();
      chk("nom_idle_busy", 32'(busy), 32'd0);
      chk("nom_pulse_end", 32'(resp_valid), 32'd0);
      chk("nom_hold_start", 32'(resp_start), 32'd17);

      // Range failure: value 9 exceeds history depth 8
      req_valid[0] = 1'b1;
      req_value[0] = 32'd9;
      step();
      req_valid = '0;
      chk("rng_resp_valid", 32'(resp_valid), 32'h1);
      chk("rng_err", 32'(resp_err), 32'd1);
      chk("rng_start", 32'(resp_start), 32'hFFFF_FFFF);
      chk("rng_end", 32'(resp_end), 32'hFFFF_FFFF);
      chk("rng_recalc", 32'(trk_recalculate), 32'd0);
      step();
      chk("rng_idle_busy", 32'(busy), 32'd0);
      chk("rng_idle_recalc", 32'(trk_recalculate), 32'd0);
      chk("rng_hold_err", 32'(resp_err), 32'd1);

      // Range failure against a small counter: counter 2, value 5
      do_reset();
      wait_count(32'd2);
      req_valid[1] = 1'b1;
      req_value[1] = 32'd5;
      step();
      req_valid = '0;
      chk("rngc_resp_valid", 32'(resp_valid), 32'h2);
      chk("rngc_err", 32'(resp_err), 32'd1);
      step();

      // Timeout, with value equal to the counter (boundary that passes the range check)
      chk("to_counter", trk_counter, 32'd4);
      req_valid[3] = 1'b1;
      req_value[3] = 32'd4;
      step();
      req_valid = '0;
      chk("to_issue_recalc", 32'(trk_recalculate), 32'd1);
      for (int i = 2; i <= 5; i++) begin
         step();
         chk("to_wait_noresp", 32'(resp_valid), 32'd0);
      end
      step();
      chk("to_resp_valid", 32'(resp_valid), 32'h8);
      chk("to_err", 32'(resp_err), 32'd2);
      chk("to_start", 32'(resp_start), 32'hFFFF_FFFF);
      chk("to_end", 32'(resp_end), 32'hFFFF_FFFF);
      step();

      // Fairness: all requesters held, grants rotate 0,1,2,3,0 every 5 cycles
      do_reset();
      req_valid = 4'hF;
      req_value = '0;
      for (int g = 0; g < 5; g++) begin
         #1 chk("fair_ready", 32'(req_ready), 32'(1) << (g % 4));
         step();
         step();
         trk_data_valid  = 1'b1;
         trk_time_out[0] = 32'(g);
         trk_time_out[1] = 32'(g + 10);
         step();
         trk_data_valid = 1'b0;
         step();
         chk("fair_resp_valid", 32'(resp_valid), 32'(1) << (g % 4));
         chk("fair_resp_start", 32'(resp_start), 32'(g));
         step();
      end
      req_valid = '0;

      // Asynchronous reset while waiting on the tracker
      req_valid[1] = 1'b1;
      req_value[1] = 32'd0;
      step();
      req_valid = '0;
      step();
      chk("ar_wait_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1 chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_recalc", 32'(trk_recalculate), 32'd0);
      chk("ar_counter", trk_counter, 32'd0);
      chk("ar_value_in", trk_value_in, 32'd0);
      chk("ar_start", 32'(resp_start), 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ar_noresp", 32'(resp_valid), 32'd0);
      end
      rst = 1'b0;
      req_valid[2] = 1'b1;
      req_value[2] = 32'd0;
      #1 chk("ar_ready2", 32'(req_ready), 32'h4);
      step();
      req_valid = '0;
      step();
      trk_data_valid  = 1'b1;
      trk_time_out[0] = 32'd5;
      trk_time_out[1] = 32'd6;
      step();
      trk_data_valid = 1'b0;
      step();
      chk("ar_resp_valid", 32'(resp_valid), 32'h4);
      chk("ar_resp_start", 32'(resp_start), 32'd5);
      chk("ar_resp_end", 32'(resp_end), 32'd6);
      step();

      // Stale tracker result in IDLE: one CLEAR, no response, then normal grant
      trk_data_valid = 1'b1;
      req_valid[0]   = 1'b1;
      req_value[0]   = 32'd0;
      #1 chk("st_ready_blocked", 32'(req_ready), 32'd0);
      step();
      chk("st_clear_recalc", 32'(trk_recalculate), 32'd1);
      chk("st_clear_busy", 32'(busy), 32'd1);
      trk_data_valid = 1'b0;
      step();
      chk("st_noresp", 32'(resp_valid), 32'd0);
      chk("st_idle_busy", 32'(busy), 32'd0);
      #1 chk("st_ready0", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;
      chk("st_issue_value", trk_value_in, 32'd0);
      step();
      trk_data_valid  = 1'b1;
      trk_time_out[0] = 32'd7;
      trk_time_out[1] = 32'd8;
      step();
      trk_data_valid = 1'b0;
      step();
      chk("st_resp_valid", 32'(resp_valid), 32'h1);
      chk("st_resp_start", 32'(resp_start), 32'd7);
      chk("st_resp_err", 32'(resp_err), 32'd0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
